// File: rtl/imem_pkg.sv
// Shared types and geometry for the instruction-memory line server.
// Latency/backpressure: none (declarations only).
// Holds the FSM encoding and the line and word sizes.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int BEATS    = 4;
    localparam int OFF_BITS = 4;

endpackage

// File: rtl/imem_word_ram.sv
// Word-wide backing store: asynchronous read, synchronous write, no reset.
// Latency: read is combinational; a write is visible after the edge.
// Backpressure: none, a write is accepted on every cycle we_i is high.
module imem_word_ram
    import imem_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle read of a word being written returns the old contents.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_line_server.sv
// Serves 128-bit instruction-cache refill lines from a word-wide store, one word per beat.
// Latency: ready pulses in the cycle after edge E0+4+EXTRA_LAT (E0 = acceptance edge).
// Backpressure: one request in flight; valid is ignored outside IDLE.
module imem_line_server
    import imem_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int EXTRA_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Icache_addr_i,
    input  logic              Icache_valid_req_i,
    output logic              mem_ready_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              busy_o,
    input  logic              we_i,
    input  logic [31:0]       waddr_i,
    input  logic [WORD_W-1:0] wdata_i
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(EXTRA_LAT - 1);

    state_t            state_q;
    logic [1:0]        beat_q;
    logic [3:0]        wait_q;
    logic [AW-3:0]     line_base_q;
    logic              ready_q;
    logic [LINE_W-1:0] data_q;
    logic [WORD_W-1:0] rdata;

    // Address bits outside the store and the sub-word/sub-line offsets are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Icache_addr_i[31:AW+2], Icache_addr_i[OFF_BITS-1:0],
                                waddr_i[31:AW+2], waddr_i[1:0]};

    imem_word_ram #(
        .MEM_WORDS(MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (we_i),
        .waddr_i (waddr_i[AW+1:2]),
        .wdata_i (wdata_i),
        .raddr_i ({line_base_q, beat_q}),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            wait_q      <= 4'd0;
            line_base_q <= '0;
            ready_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Icache_valid_req_i) begin
                        line_base_q <= Icache_addr_i[AW+1:OFF_BITS];
                        beat_q      <= 2'd0;
                        if (EXTRA_LAT > 0) begin
                            wait_q  <= WAIT_INIT;
                            state_q <= WAIT;
                        end else begin
                            state_q <= BEAT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_q == 4'd0) begin
                        beat_q  <= 2'd0;
                        state_q <= BEAT;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                BEAT: begin
                    data_q[{beat_q, 5'd0} +: WORD_W] <= rdata;
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_data_o  = data_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_line_server.sv
// Directed and randomized bench for imem_line_server, two instances (EXTRA_LAT 0 and 3)
// sharing the write port and reset, checked against an array model of the store.
module tb_imem_line_server;

    localparam int MEM_WORDS = 4096;
    localparam int LINES     = MEM_WORDS / 4;

    logic         clk;
    logic         rst_n;
    logic [31:0]  addr0, addr3;
    logic         valid0, valid3;
    logic         ready0, ready3;
    logic [127:0] data0, data3;
    logic         busy0, busy3;
    logic         we;
    logic [31:0]  waddr;
    logic [31:0]  wdata;

    logic [31:0]  model [MEM_WORDS];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    imem_line_server #(.MEM_WORDS(MEM_WORDS), .EXTRA_LAT(0)) dut0 (
        .clk                (clk),
        .rst_n              (rst_n),
        .Icache_addr_i      (addr0),
        .Icache_valid_req_i (valid0),
        .mem_ready_o        (ready0),
        .mem_data_o         (data0),
        .busy_o             (busy0),
        .we_i               (we),
        .waddr_i            (waddr),
        .wdata_i            (wdata)
    );

    imem_line_server #(.MEM_WORDS(MEM_WORDS), .EXTRA_LAT(3)) dut3 (
        .clk                (clk),
        .rst_n              (rst_n),
        .Icache_addr_i      (addr3),
        .Icache_valid_req_i (valid3),
        .mem_ready_o        (ready3),
        .mem_data_o         (data3),
        .busy_o             (busy3),
        .we_i               (we),
        .waddr_i            (waddr),
        .wdata_i            (wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A line is the four consecutive words whose index shares (addr/16) mod LINES.
    function automatic logic [127:0] exp_line(input logic [31:0] a);
        int b;
        b = int'((a >> 4) % 32'(LINES)) * 4;
        return {model[b+3], model[b+2], model[b+1], model[b]};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
        model[int'((a >> 2) % 32'(MEM_WORDS))] = d;
    endtask

    // Starts in the sample phase (#1 after an edge); lat = edges from acceptance to ready.
    task automatic do_req(input bit sel3, input logic [31:0] a, input bit keep,
                          output int lat, output logic [127:0] line);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        if (sel3) begin addr3 = a; valid3 = 1'b1; end
        else      begin addr0 = a; valid0 = 1'b1; end
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (sel3 ? ready3 : ready0) seen = 1'b1;
        end
        lat  = seen ? n - 1 : -1;
        line = sel3 ? data3 : data0;
        @(posedge clk); #1;
        chk("ready_single_cycle", {127'd0, (sel3 ? ready3 : ready0)}, 128'd0);
        if (!keep) begin
            valid0 = 1'b0;
            valid3 = 1'b0;
        end
    endtask

    initial begin
        int           lat;
        logic [127:0] line;
        logic [127:0] old_line;
        bit           saw_ready;

        rst_n = 1'b1; addr0 = '0; addr3 = '0; valid0 = 1'b0; valid3 = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) model[i] = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready0", {127'd0, ready0}, 128'd0);
        chk("reset_data0",  data0, 128'd0);
        chk("reset_busy0",  {127'd0, busy0}, 128'd0);
        chk("reset_ready3", {127'd0, ready3}, 128'd0);
        chk("reset_data3",  data3, 128'd0);
        chk("reset_busy3",  {127'd0, busy3}, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) wr(32'(i * 4), 32'hA0 + 32'(i));

        do_req(1'b0, 32'h10, 1'b0, lat, line);
        chk("lat0_basic", 128'(lat), 128'd4);
        chk("line_basic", line, 128'h000000A7_000000A6_000000A5_000000A4);

        // Valid dropped after ready: no second transfer.
        saw_ready = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready0 || busy0) saw_ready = 1'b1;
        end
        chk("single_transfer", {127'd0, saw_ready}, 128'd0);

        do_req(1'b0, 32'h1C, 1'b0, lat, line);
        chk("lat0_offset", 128'(lat), 128'd4);
        chk("line_offset", line, 128'h000000A7_000000A6_000000A5_000000A4);

        do_req(1'b1, 32'h1C, 1'b0, lat, line);
        chk("lat3_offset", 128'(lat), 128'd7);
        chk("line_lat3", line, 128'h000000A7_000000A6_000000A5_000000A4);

        // Valid kept high through RESP: next request accepted on the edge after RESP.
        do_req(1'b0, 32'h0, 1'b1, lat, line);
        chk("b2b_first_lat", 128'(lat), 128'd4);
        chk("b2b_first_line", line, 128'h000000A3_000000A2_000000A1_000000A0);
        do_req(1'b0, 32'h10, 1'b0, lat, line);
        chk("b2b_second_lat", 128'(lat), 128'd4);
        chk("b2b_second_line", line, exp_line(32'h10));

        // Write to the beat-2 word during beat 2.
        old_line = exp_line(32'h10);
        addr0 = 32'h10; valid0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        we = 1'b1; waddr = 32'h18; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        we = 1'b0;
        model[6] = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("collision_ready", {127'd0, ready0}, 128'd1);
        chk("collision_old_value", data0, old_line);
        @(posedge clk); #1;
        valid0 = 1'b0;
        do_req(1'b0, 32'h10, 1'b0, lat, line);
        chk("rewrite_line", line, exp_line(32'h10));
        chk("rewrite_word2", {96'd0, line[95:64]}, 128'hDEADBEEF);

        for (int i = 8; i < 64; i++) wr(32'(i * 4), $urandom);

        // Reset during beat 1.
        addr0 = 32'h20; valid0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; valid0 = 1'b0;
        #1;
        chk("midreset_busy", {127'd0, busy0}, 128'd0);
        chk("midreset_data", data0, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        saw_ready = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready0) saw_ready = 1'b1;
        end
        chk("midreset_no_ready", {127'd0, saw_ready}, 128'd0);
        chk("midreset_data_after", data0, 128'd0);
        chk("midreset_busy_after", {127'd0, busy0}, 128'd0);
        do_req(1'b0, 32'h20, 1'b0, lat, line);
        chk("postreset_lat", 128'(lat), 128'd4);
        chk("postreset_line", line, exp_line(32'h20));

        do_req(1'b0, 32'h4000, 1'b0, lat, line);
        chk("alias_line", line, 128'h000000A3_000000A2_000000A1_000000A0);

        for (int it = 0; it < 10; it++) begin
            bit          sel;
            logic [31:0] a;
            for (int k = 0; k < 2; k++) begin
                logic [31:0] wa;
                wa = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 63)) << 2);
                wr(wa, $urandom);
            end
            sel = 1'($urandom_range(0, 1));
            a   = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 15)) << 4);
            do_req(sel, a, 1'b0, lat, line);
            chk("rand_lat", 128'(lat), sel ? 128'd7 : 128'd4);
            chk("rand_line", line, exp_line(a));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/imem_line_server.md
# imem_line_server

Instruction-memory responder on the memory side of the instruction-cache refill interface. It accepts a line-fill request (32-bit address and valid), reads four 32-bit words from a word-wide backing store over four cycles, and returns the assembled 128-bit line with a one-cycle ready pulse. A word write port lets the program loader or bench fill the store.

## Interface
- `MEM_WORDS`, default 4096: depth of the backing store in 32-bit words; must be a power of 2, at least 4.
- `EXTRA_LAT`, default 0: wait cycles inserted between request acceptance and the first beat; range 0..15.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `Icache_addr_i` input, 32 bits: byte address of the requested line; bits [3:0] are ignored.
- `Icache_valid_req_i` input, 1 bit: refill request, held high by the requester until it sees ready.
- `mem_ready_o` output, 1 bit: registered; a one-cycle pulse meaning `mem_data_o` holds the requested line.
- `mem_data_o` output, 128 bits: registered line; word k of the line sits in bits [32k+31:32k].
- `busy_o` output, 1 bit: high in every state except IDLE.
- `we_i` input, 1 bit: word write enable.
- `waddr_i` input, 32 bits: byte address of the write; bits [1:0] are ignored.
- `wdata_i` input, 32 bits: write data.

## Operation
- States:
  - IDLE: waits for a request.
  - WAIT: latency countdown.
  - BEAT: reads words 0..3 of the line.
  - RESP: drives the ready pulse.
- Transitions:
  - IDLE → WAIT when `Icache_valid_req_i` = 1 and `EXTRA_LAT` > 0.
  - IDLE → BEAT when `Icache_valid_req_i` = 1 and `EXTRA_LAT` = 0.
  - WAIT → BEAT when the countdown reaches 0.
  - BEAT → RESP after beat 3 is captured.
  - RESP → IDLE unconditionally.
- Request capture: on acceptance, latch `line_base` = `Icache_addr_i`[AW+1:4], where AW = log2(`MEM_WORDS`). Address bits above AW+1 are ignored, so addresses alias modulo the store size.
- Beat counter: 2 bits, cleared on entry to BEAT. Each BEAT cycle reads word {`line_base`, beat} asynchronously and captures it into `mem_data_o`[32·beat+31:32·beat] at the cycle-ending edge. The counter wraps 3 → 0 on exit.
- `Icache_valid_req_i` is ignored in WAIT, BEAT and RESP. The requester clears valid in the cycle after ready, so RESP must not re-accept.
- Writes: when `we_i` = 1, store[`waddr_i`[AW+1:2]] ← `wdata_i` at the edge. Writes are accepted in every state.
- Read/write collision: a BEAT read and a write to the same word in the same cycle capture the old value.
- `mem_data_o` updates per beat during BEAT. Between ready and the first beat of the next request it holds the last line.

## Timing
- Reset values: state IDLE, `mem_ready_o` 0, `mem_data_o` 128'h0, `busy_o` 0, beat counter 0, wait counter 0. Store contents are not reset.
- Reset mid-transfer: the line is abandoned immediately and no ready pulse is issued. After `rst_n` rises, the block re-accepts on the first edge where valid is high.
- Latency: request accepted at edge E0. `mem_ready_o` = 1 during the cycle after edge E0+4+`EXTRA_LAT`, for exactly one cycle.
- Back-to-back: the earliest next acceptance is the edge ending the cycle after RESP, so the minimum spacing between ready pulses is 6+`EXTRA_LAT` cycles.
- Valid low while in IDLE: no state change.

## Structure
- Shared package `imem_pkg`:
  - state enum (2 bits: IDLE=0, WAIT=1, BEAT=2, RESP=3);
  - `LINE_W`=128, `WORD_W`=32, `BEATS`=4, `OFF_BITS`=4.
- One sub-module, `imem_word_ram`: `MEM_WORDS`×32 array with asynchronous read and synchronous write, no reset.
- The FSM, counters and line register sit in the top level.

## Test plan
- Reset, then load words 0x0..0x7 with 0xA0..0xA7 via `we_i`. Request 0x00000010, `EXTRA_LAT`=0:
  - `mem_ready_o` pulses in the cycle after E0+4;
  - `mem_data_o` = {A7,A6,A5,A4}.
- Request 0x0000001C (offset bits set): the same line as 0x10 is returned. With `EXTRA_LAT`=3, ready arrives after E0+7.
- Valid held high through ready and deasserted one cycle later: exactly one transfer and one ready pulse. Valid is re-asserted in the cycle after RESP: the second transfer is accepted immediately.
- Write 0xDEADBEEF to the word read in beat 2, in the same cycle as beat 2: the line carries the old value. Re-request the line: it carries 0xDEADBEEF.
- Assert `rst_n`=0 during beat 1, release, keep valid low:
  - no ready pulse;
  - `mem_data_o`=0, `busy_o`=0;
  - store contents preserved on the next request.
- `MEM_WORDS`=4096, request 0x00004000 (aliases word 0): the line of words 0..3 is returned.
